shifter_seq: RTL

Multi-cycle shifter-operand/offset generator for the data path. Decodes the ARM instruction word and produces the shifter operand and carry-out for data processing, or the address offset for load/store and branch. Adds shift-by-register and full ARM shift semantics: #0 special cases, amounts ≥32, RRX and carry-out. Shifts iteratively, STEP bits per cycle, behind a start/done handshake so the control unit can trade latency for area.

---
 rtl/shifter_pkg.sv | 50 +++++
 rtl/shift_step.sv | 58 +++++
 rtl/shifter_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shifter_pkg
// Description : Shared types and constants for the shifter operand generator.
// Revision    : 1.0 - initial release
// ============================================================================
package shifter_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] LSL = 2'b00;
    localparam logic [1:0] LSR = 2'b01;
    localparam logic [1:0] ASR = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        MODE_ROT_IMM   = 3'd0,
        MODE_SHIFT_IMM = 3'd1,
        MODE_SHIFT_REG = 3'd2,
        MODE_LS3       = 3'd3,
        MODE_LS2       = 3'd4,
        MODE_BRANCH    = 3'd5,
        MODE_ERR       = 3'd6
    } amode_t;

    // op = ir[27:25], b7 = ir[7], b4 = ir[4]
    function automatic amode_t decode_mode(input logic [2:0] op, input logic b7,
                                           input logic b4);
        amode_t m;
        if (op == 3'b001)
            m = MODE_ROT_IMM;
        else if (op == 3'b000)
            m = !b4 ? MODE_SHIFT_IMM : (!b7 ? MODE_SHIFT_REG : MODE_LS3);
        else if (op[2:1] == 2'b01)
            m = MODE_LS2;
        else if (op == 3'b101)
            m = MODE_BRANCH;
        else
            m = MODE_ERR;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_step
// Description : One combinational shift slice of 0..STEP bits with carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step
    import shifter_pkg::*;
#(
    parameter int STEP = 4,
    parameter int NW   = $clog2(STEP + 1)
) (
    input  logic [DATA_W-1:0] i_value,
    input  logic [1:0]        i_type,
    input  logic [NW-1:0]     i_n,
    input  logic              i_carry,
    output logic [DATA_W-1:0] o_value,
    output logic              o_carry
);

    logic [DATA_W:0]   w_lsl;
    logic [DATA_W:0]   w_lsr;
    logic [DATA_W:0]   w_asr;
    logic [DATA_W-1:0] w_ror;

    // The extra bit on each side captures the last bit shifted out.
    assign w_lsl = {1'b0, i_value} << i_n;
    assign w_lsr = {i_value, 1'b0} >> i_n;
    assign w_asr = $signed({i_value, 1'b0}) >>> i_n;
    assign w_ror = DATA_W'({i_value, i_value} >> i_n);

    always_comb begin
        o_value = i_value;
        o_carry = i_carry;
        if (i_n != '0) begin
            case (i_type)
                LSL: begin
                    o_value = w_lsl[DATA_W-1:0];
                    o_carry = w_lsl[DATA_W];
                end
                LSR: begin
                    o_value = w_lsr[DATA_W:1];
                    o_carry = w_lsr[0];
                end
                ASR: begin
                    o_value = w_asr[DATA_W:1];
                    o_carry = w_asr[0];
                end
                default: begin
                    o_value = w_ror;
                    o_carry = w_ror[DATA_W-1];
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shifter_seq.sv
`default_nettype none
// ============================================================================
// Module      : shifter_seq
// Description : Iterative ARM shifter-operand / address-offset generator.
//               Define SHIFTER_REG_SHIFT_EN to enable shift-by-register.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_seq
    import shifter_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] ir,
    input  logic [DATA_W-1:0] rm,
    input  logic [7:0]        rs,
    input  logic              c_in,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] out,
    output logic              c_out,
    output logic              err
);

    localparam int NW = $clog2(STEP + 1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_val;
    logic [1:0]        r_type;
    logic [5:0]        r_rem;
    logic              r_carry;
    logic [DATA_W-1:0] r_out;
    logic              r_cout;
    logic              r_err;

    amode_t            w_mode;
    logic              w_accept;
    logic              w_iter;
    logic              w_shift;
    logic              w_rrx;
    logic              w_err;
    logic [DATA_W-1:0] w_val;
    logic [1:0]        w_type;
    logic [7:0]        w_amt8;
    logic [5:0]        w_amt;
    logic [DATA_W-1:0] w_res_out;
    logic              w_res_c;
    logic [NW-1:0]     w_n;
    logic              w_last;
    logic [DATA_W-1:0] w_step_val;
    logic              w_step_c;
    logic              w_unused;

`ifdef SHIFTER_REG_SHIFT_EN
    assign w_unused = ^{ir[31:28], ir[24]};
`else
    assign w_unused = ^{ir[31:28], ir[24], rs};
`endif

    assign ready    = (r_state != SHIFT);
    assign done     = (r_state == DONE);
    assign out      = r_out;
    assign c_out    = r_cout;
    assign err      = done & r_err;
    assign w_accept = start & ready;
    assign w_mode   = decode_mode(ir[27:25], ir[7], ir[4]);
    assign w_amt    = {1'b0, w_amt8[4:0]};

    // Decode at accept: either a fully resolved result or an iterative job.
    always_comb begin
        w_err     = 1'b0;
        w_iter    = 1'b0;
        w_shift   = 1'b0;
        w_rrx     = 1'b0;
        w_val     = rm;
        w_type    = ir[6:5];
        w_amt8    = '0;
        w_res_out = '0;
        w_res_c   = c_in;
        case (w_mode)
            MODE_ROT_IMM: begin
                w_val   = {24'b0, ir[7:0]};
                w_type  = ROR;
                w_amt8  = {3'b0, ir[11:8], 1'b0};
                w_shift = 1'b1;
            end
            MODE_SHIFT_IMM: begin
                w_amt8  = {3'b0, ir[11:7]};
                w_shift = 1'b1;
                if (ir[11:7] == 5'd0) begin
                    case (ir[6:5])
                        LSL:     w_amt8 = 8'd0;
                        ROR:     w_rrx  = 1'b1;
                        default: w_amt8 = 8'd32;
                    endcase
                end
            end
`ifdef SHIFTER_REG_SHIFT_EN
            MODE_SHIFT_REG: begin
                w_amt8  = rs;
                w_shift = 1'b1;
            end
`endif
            MODE_LS3:    w_res_out = ir[22] ? {24'b0, ir[11:8], ir[3:0]} : rm;
            MODE_LS2:    w_res_out = ir[25] ? rm : {20'b0, ir[11:0]};
            MODE_BRANCH: w_res_out = {{6{ir[23]}}, ir[23:0], 2'b00};
            default:     w_err     = 1'b1;
        endcase

        if (w_rrx) begin
            w_res_out = {c_in, rm[DATA_W-1:1]};
            w_res_c   = rm[0];
        end else if (w_shift) begin
            if (w_amt8 == 8'd0) begin
                w_res_out = w_val;
            end else begin
                case (w_type)
                    LSL: begin
                        w_iter  = (w_amt8 < 8'd32);
                        w_res_c = (w_amt8 == 8'd32) & w_val[0];
                    end
                    LSR: begin
                        w_iter  = (w_amt8 < 8'd32);
                        w_res_c = (w_amt8 == 8'd32) & w_val[DATA_W-1];
                    end
                    ASR: begin
                        w_iter    = (w_amt8 < 8'd32);
                        w_res_out = {DATA_W{w_val[DATA_W-1]}};
                        w_res_c   = w_val[DATA_W-1];
                    end
                    default: begin
                        w_iter    = (w_amt8[4:0] != 5'd0);
                        w_res_out = w_val;
                        w_res_c   = w_val[DATA_W-1];
                    end
                endcase
            end
        end
    end

    assign w_n    = (r_rem > 6'(STEP)) ? NW'(STEP) : NW'(r_rem);
    assign w_last = (r_rem <= 6'(STEP));

    shift_step #(
        .STEP (STEP),
        .NW   (NW)
    ) u_step (
        .i_value (r_val),
        .i_type  (r_type),
        .i_n     (w_n),
        .i_carry (r_carry),
        .o_value (w_step_val),
        .o_carry (w_step_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_iter ? SHIFT : DONE;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? (w_iter ? SHIFT : DONE) : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val   <= '0;
            r_type  <= LSL;
            r_rem   <= '0;
            r_carry <= 1'b0;
            r_out   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (w_iter) begin
                r_val   <= w_val;
                r_type  <= w_type;
                r_rem   <= w_amt;
                r_carry <= c_in;
                r_err   <= 1'b0;
            end else begin
                r_out  <= w_res_out;
                r_cout <= w_res_c;
                r_err  <= w_err;
            end
        end else if (r_state == SHIFT) begin
            r_val   <= w_step_val;
            r_carry <= w_step_c;
            r_rem   <= r_rem - 6'(w_n);
            if (w_last) begin
                r_out  <= w_step_val;
                r_cout <= w_step_c;
            end
        end
    end

endmodule
`default_nettype wire
